// File: rtl/alu_seg_display_if.sv
// alu_seg_display_if: ALU result bus feeding the display stage
//   op[2:0]      ALU op code
//   result[3:0]  ALU result, two's complement
//   carry        ALU carry flag
//   zero         ALU zero flag
//   overflow     ALU signed-overflow flag
//   master = ALU side (drives), slave = display side (samples)
interface alu_seg_display_if;
    logic [2:0] op;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       overflow;
    modport master (output op, result, carry, zero, overflow);
    modport slave  (input  op, result, carry, zero, overflow);
endinterface

// File: rtl/alu_seg_display.sv
// alu_seg_display: snapshots the ALU bus once per frame and drives a 4-digit
// multiplexed active-low seven-segment display plus three flag LEDs.
//   SCAN_DIV        cycles each digit stays lit (>= 2)
//   clk, rst        clock, asynchronous active-high reset
//   alu             ALU bus (slave modport)
//   an[3:0]         digit enables, active-low
//   seg[6:0]        segments {g,f,e,d,c,b,a}, active-low
//   led_zero/carry/overflow  snapshot flags
// Define ALU_DISP_HEX_EN to show the result as unsigned hex instead of
// signed decimal.
module alu_seg_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_seg_display_if.slave         alu,
    output logic [3:0]               an,
    output logic [6:0]               seg,
    output logic                     led_zero,
    output logic                     led_carry,
    output logic                     led_overflow
);
    localparam int W = $clog2(SCAN_DIV);

    logic [W-1:0] cnt;
    logic [1:0]   idx;
    logic [2:0]   s_op;
    logic [3:0]   s_res;
    logic         s_c, s_z, s_v;
    logic         live;
    logic         wrap;
    logic [3:0]   mag;
    logic [6:0]   sign, seg_n;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign wrap = cnt == W'(SCAN_DIV - 1);

`ifdef ALU_DISP_HEX_EN
    assign mag  = s_res;
    assign sign = 7'h7F;
`else
    // 4-bit negate maps -8 back onto 4'b1000, which still decodes as 8
    assign mag  = s_res[3] ? -s_res : s_res;
    assign sign = s_res[3] ? 7'h3F : 7'h7F;
`endif

    always_comb begin
        seg_n = idx == 2'd0 ? hex7(mag) :
                idx == 2'd1 ? sign :
                idx == 2'd2 ? hex7({1'b0, s_op}) :
                s_v ? 7'h23 : s_c ? 7'h27 : 7'h7F;
    end

    // live stays low until the first snapshot so the display is blank
    // instead of showing digit 3 of an empty frame after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= 2'd3;
            s_op         <= '0;
            s_res        <= '0;
            s_c          <= 1'b0;
            s_z          <= 1'b0;
            s_v          <= 1'b0;
            live         <= 1'b0;
            an           <= 4'hF;
            seg          <= 7'h7F;
            led_zero     <= 1'b0;
            led_carry    <= 1'b0;
            led_overflow <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    s_op  <= alu.op;
                    s_res <= alu.result;
                    s_c   <= alu.carry;
                    s_z   <= alu.zero;
                    s_v   <= alu.overflow;
                    live  <= 1'b1;
                end
            end
            an           <= live ? ~(4'b0001 << idx) : 4'hF;
            seg          <= live ? seg_n : 7'h7F;
            led_zero     <= s_z;
            led_carry    <= s_c;
            led_overflow <= s_v;
        end
    end
endmodule

// File: tb/tb_alu_seg_display.sv
// tb_alu_seg_display: randomized and directed frames checked against a
// digit-level reference model of the display.
module tb_alu_seg_display;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an;
    logic [6:0] seg;
    logic       led_zero, led_carry, led_overflow;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] r;
        logic       c, z, v;
    } vec_t;

    alu_seg_display_if bus ();

    alu_seg_display #(.SCAN_DIV(4)) dut (
        .clk(clk),
        .rst(rst),
        .alu(bus.slave),
        .an(an),
        .seg(seg),
        .led_zero(led_zero),
        .led_carry(led_carry),
        .led_overflow(led_overflow)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] DIG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [6:0] exp_seg(input int d, input vec_t e);
        int sv, m;
        logic neg;
`ifdef ALU_DISP_HEX_EN
        m   = int'(e.r);
        neg = 1'b0;
`else
        sv  = e.r >= 4'd8 ? int'(e.r) - 16 : int'(e.r);
        m   = sv < 0 ? -sv : sv;
        neg = sv < 0;
`endif
        if (d == 0) return DIG[m];
        if (d == 1) return neg ? 7'h3F : 7'h7F;
        if (d == 2) return DIG[int'(e.op)];
        return e.v ? 7'h23 : e.c ? 7'h27 : 7'h7F;
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input vec_t n);
        bus.op       = n.op;
        bus.result   = n.r;
        bus.carry    = n.c;
        bus.zero     = n.z;
        bus.overflow = n.v;
    endtask

    // Checks one whole frame showing snapshot e; switches inputs to n while
    // digit 1 is lit, which must only show up in the following frame.
    task automatic run_frame(input vec_t e, input vec_t n);
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 4; k++) begin
                if (d == 1 && k == 0) drive(n);
                chk("an", {3'b000, an}, 7'(15 - (1 << d)));
                chk("seg", seg, exp_seg(d, e));
                chk("leds", {4'b0000, led_zero, led_carry, led_overflow}, {4'b0000, e.z, e.c, e.v});
                @(negedge clk);
            end
    endtask

    task automatic blank_until_first();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("an_blank", {3'b000, an}, 7'h0F);
        end
        @(negedge clk);
        chk("first_an", {3'b000, an}, 7'h0E);
    endtask

    initial begin
        vec_t cur, nxt;
        cur = '{op: 3'd0, r: 4'b0011, c: 1'b0, z: 1'b0, v: 1'b0};
        drive(cur);
        repeat (3) @(negedge clk);
        chk("rst_an", {3'b000, an}, 7'h0F);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_leds", {4'b0000, led_zero, led_carry, led_overflow}, 7'h00);
        rst = 1'b0;
        blank_until_first();
        nxt = '{op: 3'd5, r: 4'b1000, c: 1'b1, z: 1'b0, v: 1'b1};
        run_frame(cur, nxt);
        cur = nxt;
        nxt = '{op: 3'd2, r: 4'b0000, c: 1'b1, z: 1'b1, v: 1'b0};
        run_frame(cur, nxt);
        cur = nxt;
        nxt = '{op: 3'd0, r: 4'b0011, c: 1'b0, z: 1'b0, v: 1'b0};
        run_frame(cur, nxt);
        cur = nxt;
        nxt = '{op: 3'd0, r: 4'b1111, c: 1'b0, z: 1'b0, v: 1'b0};
        run_frame(cur, nxt);
        for (int i = 0; i < 10; i++) begin
            cur = nxt;
            nxt.op = 3'($urandom_range(0, 7));
            nxt.r  = 4'($urandom_range(0, 15));
            nxt.c  = 1'($urandom_range(0, 1));
            nxt.z  = 1'($urandom_range(0, 1));
            nxt.v  = 1'($urandom_range(0, 1));
            run_frame(cur, nxt);
        end
        cur = nxt;
        for (int k = 0; k < 6; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_an", {3'b000, an}, 7'h0F);
        chk("async_seg", seg, 7'h7F);
        chk("async_leds", {4'b0000, led_zero, led_carry, led_overflow}, 7'h00);
        @(negedge clk);
        rst = 1'b0;
        blank_until_first();
        run_frame(cur, cur);
        run_frame(cur, cur);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
